// File: rtl/rv32im_dmem_resp.sv
// rv32im_dmem_resp: memory-side responder for the LSU load/store path.
// One request at a time, programmable wait states, word array behind valid/ready.
module rv32im_dmem_resp #(
   parameter int unsigned MEM_DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_STATES     = 1,
   parameter logic [31:0] ADDR_BASE       = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   input  logic [3:0]  req_be_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o
);

   localparam int AW = $clog2(MEM_DEPTH_WORDS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic        r_we;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_be;
   logic [31:0] r_rdata;
   logic        r_err;
   logic        r_rsp_valid;
   logic        r_req_ready;

   logic [31:0] r_mem [MEM_DEPTH_WORDS];

   logic [31:0]   w_off;
   logic [29:0]   w_idx;
   logic [AW-1:0] w_aidx;
   logic          w_err;
   logic          w_access;
   logic          w_wr;
   logic          w_unused;

   // Offset wraps at 32 bits, so addresses below the base land out of range.
   assign w_off    = r_addr - ADDR_BASE;
   assign w_idx    = w_off[31:2];
   assign w_aidx   = w_idx[AW-1:0];
   assign w_err    = ({2'b00, w_idx} >= MEM_DEPTH_WORDS) || (r_be == 4'b0000);
   assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0);
   assign w_wr     = w_access && r_we && !w_err && rst_ni;
   assign w_unused = ^w_off[1:0];

   always_ff @(posedge clk_i) begin
      if (w_wr) begin
         for (int n = 0; n < 4; n++) begin
            if (r_be[n]) r_mem[w_aidx][8*n +: 8] <= r_wdata[8*n +: 8];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= S_IDLE;
         r_cnt       <= 4'd0;
         r_we        <= 1'b0;
         r_addr      <= 32'd0;
         r_wdata     <= 32'd0;
         r_be        <= 4'd0;
         r_rdata     <= 32'd0;
         r_err       <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_req_ready <= 1'b1;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (req_valid_i && r_req_ready) begin
                  r_we        <= req_we_i;
                  r_addr      <= req_addr_i;
                  r_wdata     <= req_wdata_i;
                  r_be        <= req_be_i;
                  r_cnt       <= 4'(WAIT_STATES);
                  r_req_ready <= 1'b0;
                  r_state     <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  r_rdata     <= (w_err || r_we) ? 32'd0 : r_mem[w_aidx];
                  r_err       <= w_err;
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_RESP;
               end
            end
            S_RESP: begin
               if (rsp_ready_i) begin
                  r_rsp_valid <= 1'b0;
                  r_rdata     <= 32'd0;
                  r_err       <= 1'b0;
                  r_req_ready <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_rsp_valid <= 1'b0;
               r_req_ready <= 1'b1;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign req_ready_o = r_req_ready;
   assign rsp_valid_o = r_rsp_valid;
   assign rsp_rdata_o = r_rdata;
   assign rsp_err_o   = r_err;

endmodule
